// File: rtl/tx_mem_arbiter.sv
// Round-robin arbiter that grants bursts of transaction-memory beats
// to the loader, hash engine and signer over one shared memory port.
module tx_mem_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 256,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy,
    output logic [1:0]                owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] MAXB = 3'(MAX_BURST);

    state_t     state, state_nx;
    logic [1:0] last_owner;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic [2:0] beat_cnt;
    logic [2:0] beat_inc;
    logic       accept;
    logic       end_burst;

    // Scan starts just past the previous owner so nobody starves.
    always_comb begin
        pick  = last_owner;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((32'(last_owner) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign accept    = (state == OWN) && req[owner];
    assign beat_inc  = (beat_cnt == 3'd7) ? beat_cnt : beat_cnt + 3'd1;
    assign end_burst = !req[owner] || req_last[owner] || (beat_inc == MAXB);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = OWN;
            OWN:     if (end_burst) state_nx = DRAIN;
            DRAIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt        <= '0;
            rvalid     <= '0;
            owner      <= '0;
            last_owner <= 2'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            rvalid <= '0;
            if (accept && !req_we[owner]) rvalid[owner] <= 1'b1;
            case (state)
                IDLE: begin
                    gnt <= '0;
                    if (found) begin
                        gnt[pick]  <= 1'b1;
                        owner      <= pick;
                        last_owner <= pick;
                        beat_cnt   <= '0;
                    end
                end
                OWN: begin
                    if (accept) beat_cnt <= beat_inc;
                    if (end_burst) gnt <= '0;
                end
                default: gnt <= '0;
            endcase
        end
    end

    // Memory port follows the owner's slices only while a beat is taken.
    assign mem_en    = accept;
    assign mem_we    = accept && req_we[owner];
    assign mem_addr  = accept ? req_addr[owner*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = accept ? req_wdata[owner*DATA_W +: DATA_W] : '0;
    assign rdata     = (|rvalid) ? mem_rdata : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_tx_mem_arbiter.sv
// Directed vector bench for tx_mem_arbiter with a registered memory
// model that returns an address-derived pattern.
module tb_tx_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req, req_we, req_last;
    logic [29:0]  req_addr;
    logic [767:0] req_wdata;
    logic [2:0]   gnt, rvalid;
    logic [255:0] rdata, mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_en, mem_we, busy;
    logic [9:0]   mem_addr;
    logic [1:0]   owner;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tx_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_last(req_last),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [255:0] pat(input logic [9:0] a);
        pat = {32{4'hA, a[3:0]}};
    endfunction

    function automatic logic [255:0] wd(input logic [1:0] o);
        logic [3:0] n;
        n = {2'b00, o} + 4'd1;
        wd = {64{n}};
    endfunction

    always @(posedge clk)
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);

    typedef struct {
        logic [2:0] req, we, last;
        logic [7:0] a;
        logic [2:0] gnt;
        logic       en, wr;
        logic [9:0] addr;
        logic [2:0] rv;
        logic       busy;
        logic [1:0] own;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(
        input logic [2:0] r, w, l, input logic [7:0] a,
        input logic [2:0] g, input logic en, wr, input logic [9:0] ad,
        input logic [2:0] rv, input logic b, input logic [1:0] o);
        vec_t t;
        t.req = r; t.we = w; t.last = l; t.a = a;
        t.gnt = g; t.en = en; t.wr = wr; t.addr = ad;
        t.rv = rv; t.busy = b; t.own = o;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, w, l, input logic [7:0] a);
        req = r; req_we = w; req_last = l;
        for (int i = 0; i < 3; i++) begin
            req_addr[i*10 +: 10]   = {2'(i), a};
            req_wdata[i*256 +: 256] = wd(2'(i));
        end
    endtask

    initial begin
        logic [9:0] prev_addr;
        vec_t t;
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 8'h00);

        // all requesters at once, then fair rotation
        vq.push_back(v(3'b000,3'b000,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd0));
        vq.push_back(v(3'b111,3'b111,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd0));
        vq.push_back(v(3'b111,3'b111,3'b000,8'h00, 3'b001,1,1,10'h000,3'b000,1,2'd0));
        vq.push_back(v(3'b111,3'b111,3'b000,8'h01, 3'b001,1,1,10'h001,3'b000,1,2'd0));
        vq.push_back(v(3'b111,3'b111,3'b000,8'h02, 3'b001,1,1,10'h002,3'b000,1,2'd0));
        vq.push_back(v(3'b111,3'b111,3'b000,8'h03, 3'b001,1,1,10'h003,3'b000,1,2'd0));
        vq.push_back(v(3'b111,3'b111,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,1,2'd0));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd0));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h00, 3'b010,1,0,10'h100,3'b000,1,2'd1));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h01, 3'b010,1,0,10'h101,3'b010,1,2'd1));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h02, 3'b010,1,0,10'h102,3'b010,1,2'd1));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h03, 3'b010,1,0,10'h103,3'b010,1,2'd1));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h00, 3'b000,0,0,10'h000,3'b010,1,2'd1));
        vq.push_back(v(3'b111,3'b001,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd1));
        vq.push_back(v(3'b111,3'b001,3'b100,8'h00, 3'b100,1,0,10'h200,3'b000,1,2'd2));
        vq.push_back(v(3'b000,3'b000,3'b000,8'h00, 3'b000,0,0,10'h000,3'b100,1,2'd2));
        vq.push_back(v(3'b000,3'b000,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd2));
        // single-beat read returned during DRAIN
        vq.push_back(v(3'b010,3'b000,3'b010,8'h05, 3'b000,0,0,10'h000,3'b000,0,2'd2));
        vq.push_back(v(3'b010,3'b000,3'b010,8'h05, 3'b010,1,0,10'h105,3'b000,1,2'd1));
        vq.push_back(v(3'b000,3'b000,3'b000,8'h05, 3'b000,0,0,10'h000,3'b010,1,2'd1));
        vq.push_back(v(3'b000,3'b000,3'b000,8'h05, 3'b000,0,0,10'h000,3'b000,0,2'd1));
        // six writes split by the burst limit
        vq.push_back(v(3'b100,3'b100,3'b000,8'h10, 3'b000,0,0,10'h000,3'b000,0,2'd1));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h10, 3'b100,1,1,10'h210,3'b000,1,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h11, 3'b100,1,1,10'h211,3'b000,1,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h12, 3'b100,1,1,10'h212,3'b000,1,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h13, 3'b100,1,1,10'h213,3'b000,1,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h14, 3'b000,0,0,10'h000,3'b000,1,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h14, 3'b000,0,0,10'h000,3'b000,0,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b000,8'h14, 3'b100,1,1,10'h214,3'b000,1,2'd2));
        vq.push_back(v(3'b100,3'b100,3'b100,8'h15, 3'b100,1,1,10'h215,3'b000,1,2'd2));
        vq.push_back(v(3'b000,3'b000,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,1,2'd2));
        vq.push_back(v(3'b000,3'b000,3'b000,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd2));
        // owner abandons its burst early
        vq.push_back(v(3'b011,3'b011,3'b000,8'h20, 3'b000,0,0,10'h000,3'b000,0,2'd2));
        vq.push_back(v(3'b011,3'b011,3'b000,8'h20, 3'b001,1,1,10'h020,3'b000,1,2'd0));
        vq.push_back(v(3'b011,3'b011,3'b000,8'h21, 3'b001,1,1,10'h021,3'b000,1,2'd0));
        vq.push_back(v(3'b010,3'b011,3'b000,8'h22, 3'b001,0,0,10'h000,3'b000,1,2'd0));
        vq.push_back(v(3'b011,3'b001,3'b000,8'h22, 3'b000,0,0,10'h000,3'b000,1,2'd0));
        vq.push_back(v(3'b011,3'b001,3'b010,8'h22, 3'b000,0,0,10'h000,3'b000,0,2'd0));
        vq.push_back(v(3'b011,3'b001,3'b010,8'h22, 3'b010,1,0,10'h122,3'b000,1,2'd1));
        vq.push_back(v(3'b000,3'b000,3'b111,8'h00, 3'b000,0,0,10'h000,3'b010,1,2'd1));
        vq.push_back(v(3'b000,3'b000,3'b111,8'h00, 3'b000,0,0,10'h000,3'b000,0,2'd1));

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        prev_addr = '0;
        for (int i = 0; i < vq.size(); i++) begin
            t = vq[i];
            @(negedge clk);
            drive(t.req, t.we, t.last, t.a);
            #1;
            chk($sformatf("v%0d gnt", i), 256'(gnt), 256'(t.gnt));
            chk($sformatf("v%0d mem_en", i), 256'(mem_en), 256'(t.en));
            chk($sformatf("v%0d mem_we", i), 256'(mem_we), 256'(t.wr));
            chk($sformatf("v%0d mem_addr", i), 256'(mem_addr), 256'(t.addr));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,
                t.en ? wd(t.own) : '0);
            chk($sformatf("v%0d rvalid", i), 256'(rvalid), 256'(t.rv));
            chk($sformatf("v%0d rdata", i), rdata,
                (t.rv != 0) ? pat(prev_addr) : '0);
            chk($sformatf("v%0d busy", i), 256'(busy), 256'(t.busy));
            chk($sformatf("v%0d owner", i), 256'(owner), 256'(t.own));
            chk($sformatf("v%0d gnt_onehot", i), 256'($onehot0(gnt)), 256'(1));
            prev_addr = t.addr;
        end

        // reset lands the cycle after a read beat, mid-burst
        @(negedge clk);
        drive(3'b010, 3'b000, 3'b000, 8'h30);
        #1 chk("rst idle gnt", 256'(gnt), 256'(0));
        @(negedge clk);
        #1 chk("rst beat1 en", 256'(mem_en), 256'(1));
        chk("rst beat1 gnt", 256'(gnt), 256'(3'b010));
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst rvalid pre", 256'(rvalid), 256'(3'b010));
        chk("rst rdata pre", rdata, pat(10'h130));
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b111, 3'b000, 3'b000, 8'h00);
        #1 chk("rst gnt", 256'(gnt), 256'(0));
        chk("rst rvalid", 256'(rvalid), 256'(0));
        chk("rst mem_en", 256'(mem_en), 256'(0));
        chk("rst busy", 256'(busy), 256'(0));
        chk("rst owner", 256'(owner), 256'(0));
        chk("rst rdata", rdata, '0);
        @(negedge clk);
        #1 chk("post rst gnt", 256'(gnt), 256'(3'b001));
        chk("post rst owner", 256'(owner), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_mem_arbiter.md
TX_MEM_ARBITER -- requirements
Module: tx_mem_arbiter

Interface
REQ-001 Parameter NUM_REQ, 3, number of requesters (0 loader, 1 hash engine, 2 signer).
REQ-002 Parameter ADDR_W, 10, transaction-memory address width (1K entries).
REQ-003 Parameter DATA_W, 256, memory word width.
REQ-004 Parameter MAX_BURST, 4, maximum beats per grant (range 1..7).
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 req  input  NUM_REQ  per-requester access request; stays high while beats remain.
REQ-008 req_we  input  NUM_REQ  per-requester write (1) / read (0).
REQ-009 req_addr  input  NUM_REQ*ADDR_W  per-requester address; slice i at [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  NUM_REQ*DATA_W  per-requester write data, sliced the same way.
REQ-011 req_last  input  NUM_REQ  marks the final beat of a burst.
REQ-012 gnt  output  NUM_REQ  registered one-hot grant.
REQ-013 rvalid  output  NUM_REQ  one-hot read-data valid.
REQ-014 rdata  output  DATA_W  read data, shared by all requesters.
REQ-015 mem_en, mem_we  output  1 each  memory port strobe and write enable.
REQ-016 mem_addr  output  ADDR_W;  mem_wdata  output  DATA_W  memory port address and write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.
REQ-018 busy  output  1;  owner  output  2  state not IDLE; index of the current or last grantee.

Function
REQ-019 States: IDLE, OWN, DRAIN (2-bit encoding).
REQ-020 IDLE with any req high: select the first requester with req high, scanning round-robin from (last_owner+1) mod NUM_REQ.
  - Register gnt one-hot and set owner/last_owner.
  - Next state OWN; request-to-grant latency exactly 1 cycle.
REQ-021 IDLE with no req: gnt=0 and mem_en=0.
REQ-022 Beat acceptance: a beat is accepted in any OWN cycle where req[owner]=1.
  - mem_en=1.
  - mem_we, mem_addr and mem_wdata are driven combinationally from the owner's slices.
REQ-023 OWN cycle with req[owner]=0: no beat; mem_en=0.
REQ-024 Beat counter: 3 bits, cleared on entry to OWN, incremented per accepted beat, never wraps.
REQ-025 OWN -> DRAIN when any of the following holds:
  - an accepted beat has req_last=1;
  - an accepted beat brings the beat count to MAX_BURST;
  - req[owner]=0.
  gnt clears on the same clock edge.
REQ-026 DRAIN lasts exactly 1 cycle: no grant, mem_en=0, then -> IDLE.
  - Back-to-back bursts are therefore separated by 2 idle cycles before the next gnt.
REQ-027 Read return: for each accepted read beat, rvalid[owner] is asserted the next cycle with rdata=mem_rdata.
  - This applies even when that next cycle is DRAIN.
  - Write beats produce no rvalid.
REQ-028 Simultaneous requests: exactly one grant is issued; the others wait without loss.
  - Worst-case wait: (NUM_REQ-1)*(MAX_BURST+2) cycles.
REQ-029 The gnt value is always one-hot or zero; mem_en=1 implies gnt!=0.
REQ-030 req_last accepted on the first beat gives a single-beat burst.
REQ-031 req_last asserted with req=0 is ignored.

Reset
REQ-032 rst_n=0 sampled at a rising edge sets the following, regardless of state (including mid-burst):
  - state=IDLE, gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - busy=0, owner=0, beat counter=0;
  - last_owner=NUM_REQ-1, so requester 0 has first priority after reset.
REQ-033 A read pending at reset produces no rvalid.

Verification
REQ-034 After reset, req=3'b111 -> gnt=3'b001 on the next cycle; requester 0 holds for a 4-beat burst; the following grants are 3'b010 then 3'b100, each 2 cycles after the previous burst ends.
REQ-035 Requester 1 reads address 0x005 (mem_rdata=0xA5 pattern) with req_last on beat 1 -> mem_en for 1 cycle; rvalid=3'b010 with rdata=0xA5 pattern during DRAIN; IDLE next.
REQ-036 Requester 2 issues 6 write beats with no req_last, MAX_BURST=4 -> exactly 4 mem_en writes (addresses 0x010..0x013); gnt drops; requester 2 re-granted after 2 cycles if alone; remaining 2 beats complete.
REQ-037 Owner drops req after 2 of 4 beats -> DRAIN next cycle; no further mem_en; round-robin pointer advances past that owner.
REQ-038 rst_n=0 in the cycle after a read beat -> next cycle gnt=0, rvalid=0, mem_en=0; the first grant after reset goes to requester 0 when all requests are high.
